// File: rtl/traffic_phase_controller.sv
// Two-road traffic phase controller that sequences main/side green, yellow and all-red
// phases while driving an external BCD count-down timer. Define PED_WALK_EN for pedestrian walk.
module traffic_phase_controller #(
  parameter int unsigned MAIN_TENS    = 3,
  parameter int unsigned SIDE_TENS    = 2,
  parameter int unsigned ALLRED_TICKS = 2
) (
  input  logic       myClock,
  input  logic       reset,
  input  logic       side_req,
  input  logic       cnt_not_zero,
  input  logic       cnt_not_five,
`ifdef PED_WALK_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic       cnt_load,
  output logic [1:0] cnt_tens,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic [2:0] phase
);

  localparam int unsigned AR_W    = 3;
  localparam int unsigned TENS_W  = 2;
  localparam int unsigned LIGHT_W = 3;
  localparam int unsigned STATE_W = 3;

  localparam logic [LIGHT_W-1:0] L_RED = 3'b100;
  localparam logic [LIGHT_W-1:0] L_YEL = 3'b010;
  localparam logic [LIGHT_W-1:0] L_GRN = 3'b001;

  typedef enum logic [STATE_W-1:0] {
    RED_M  = 3'd0,
    MAIN_G = 3'd1,
    MAIN_Y = 3'd2,
    RED_S  = 3'd3,
    SIDE_G = 3'd4,
    SIDE_Y = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [AR_W-1:0]      ar_q, ar_d;
  logic                 side_q, side_d;
  logic                 load_q, load_d;
  logic                 hold_q;
  logic [TENS_W-1:0]    tens_q, tens_d;
  logic [LIGHT_W-1:0]   main_q, main_d;
  logic [LIGHT_W-1:0]   sidel_q, sidel_d;

  logic status_ok;
  logic five_seen;
  logic zero_seen;
  logic ar_done;
  logic enter_side_g;
  logic serve_side;

  // Timer status is stale during the load cycle and the cycle after it.
  assign status_ok    = !load_q && !hold_q;
  // A zero without a preceding five is handled as if the five had been seen.
  assign five_seen    = !cnt_not_five || !cnt_not_zero;
  assign zero_seen    = !cnt_not_zero;
  assign ar_done      = (ar_q == AR_W'(ALLRED_TICKS - 1));
  assign enter_side_g = (state_q == RED_S) && ar_done;

`ifdef PED_WALK_EN
  logic ped_q, ped_d;
  logic walk_q, walk_d;
  logic leave_side_g;

  assign serve_side   = side_q || ped_q;
  assign leave_side_g = (state_q == SIDE_G) && (state_d == SIDE_Y);

  // Pedestrian latch and walk indication, tied to side-green entry/exit.
  always_comb begin
    ped_d  = ped_q || (ped_req && (state_q != SIDE_G));
    walk_d = walk_q;
    if (enter_side_g) begin
      walk_d = ped_q;
      ped_d  = 1'b0;
    end
    if (leave_side_g) begin
      walk_d = 1'b0;
    end
  end

  always_ff @(posedge myClock or posedge reset) begin
    if (reset) begin
      ped_q  <= 1'b0;
      walk_q <= 1'b0;
    end else begin
      ped_q  <= ped_d;
      walk_q <= walk_d;
    end
  end

  assign walk = walk_q;
`else
  assign serve_side = side_q;
`endif

  // Next-state, timer load and side latch.
  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    tens_d  = tens_q;
    side_d  = side_q || (side_req && (state_q != SIDE_G));

    case (state_q)
      RED_M: begin
        if (ar_done) begin
          state_d = MAIN_G;
          load_d  = 1'b1;
          tens_d  = TENS_W'(MAIN_TENS);
        end
      end
      MAIN_G: begin
        if (status_ok && five_seen) begin
          if (serve_side) begin
            state_d = MAIN_Y;
          end else begin
            load_d = 1'b1;
            tens_d = TENS_W'(1);
          end
        end
      end
      MAIN_Y: begin
        if (status_ok && zero_seen) begin
          state_d = RED_S;
        end
      end
      RED_S: begin
        if (ar_done) begin
          state_d = SIDE_G;
          load_d  = 1'b1;
          tens_d  = TENS_W'(SIDE_TENS);
        end
      end
      SIDE_G: begin
        if (status_ok && five_seen) begin
          state_d = SIDE_Y;
        end
      end
      SIDE_Y: begin
        if (status_ok && zero_seen) begin
          state_d = RED_M;
        end
      end
      default: begin
        state_d = RED_M;
      end
    endcase

    // Clearing on side-green entry overrides a request in the same cycle.
    if (enter_side_g) begin
      side_d = 1'b0;
    end
  end

  // All-red counter restarts on every phase change and only runs in all-red phases.
  always_comb begin
    ar_d = '0;
    if ((state_d == state_q) && ((state_q == RED_M) || (state_q == RED_S))) begin
      ar_d = ar_q + AR_W'(1);
    end
  end

  // Light pattern follows the next state so the lights register with the phase.
  always_comb begin
    main_d  = L_RED;
    sidel_d = L_RED;
    case (state_d)
      MAIN_G:  main_d  = L_GRN;
      MAIN_Y:  main_d  = L_YEL;
      SIDE_G:  sidel_d = L_GRN;
      SIDE_Y:  sidel_d = L_YEL;
      default: begin
        main_d  = L_RED;
        sidel_d = L_RED;
      end
    endcase
  end

  always_ff @(posedge myClock or posedge reset) begin
    if (reset) begin
      state_q <= RED_M;
      ar_q    <= '0;
      side_q  <= 1'b0;
      load_q  <= 1'b0;
      hold_q  <= 1'b0;
      tens_q  <= '0;
      main_q  <= L_RED;
      sidel_q <= L_RED;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      side_q  <= side_d;
      load_q  <= load_d;
      hold_q  <= load_q;
      tens_q  <= tens_d;
      main_q  <= main_d;
      sidel_q <= sidel_d;
    end
  end

  assign cnt_load   = load_q;
  assign cnt_tens   = tens_q;
  assign main_light = main_q;
  assign side_light = sidel_q;
  assign phase      = STATE_W'(state_q);

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: a BCD timer model drives the status flags and a
// duration-based phase model predicts phase, lights and timer loads every cycle.
module tb_traffic_phase_controller;

  localparam int unsigned MAIN_T = 3;
  localparam int unsigned SIDE_T = 2;
  localparam int unsigned AR     = 2;

  logic       myClock  = 1'b0;
  logic       reset    = 1'b1;
  logic       side_req = 1'b0;
  logic       inj_zero = 1'b0;
  logic       cnt_not_zero;
  logic       cnt_not_five;
  logic       cnt_load;
  logic [1:0] cnt_tens;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic [2:0] phase;

  int unsigned tmr = 0;
  int ncmp  = 0;
  int nfail = 0;

  // Reference model: phase code, cycles into the current window, window length.
  int unsigned mph   = 0;
  int unsigned mcnt  = 0;
  int unsigned mwin  = 0;
  logic        mlatch = 1'b0;
  logic        mload  = 1'b0;
  logic [1:0]  mtens  = 2'd0;

  assign cnt_not_zero = inj_zero ? 1'b0 : (tmr != 0);
  assign cnt_not_five = (tmr != 5);

  always #5 myClock = ~myClock;

  traffic_phase_controller #(
    .MAIN_TENS   (MAIN_T),
    .SIDE_TENS   (SIDE_T),
    .ALLRED_TICKS(AR)
  ) dut (
    .myClock     (myClock),
    .reset       (reset),
    .side_req    (side_req),
    .cnt_not_zero(cnt_not_zero),
    .cnt_not_five(cnt_not_five),
    .cnt_load    (cnt_load),
    .cnt_tens    (cnt_tens),
    .main_light  (main_light),
    .side_light  (side_light),
    .phase       (phase)
  );

  function automatic logic [5:0] exp_lights(input int unsigned ph);
    case (ph)
      1:       return 6'b001_100;
      2:       return 6'b010_100;
      4:       return 6'b100_001;
      5:       return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [5:0] el;
    el = exp_lights(mph);
    chk("phase",      8'(phase),      8'(mph));
    chk("main_light", 8'(main_light), 8'(el[5:3]));
    chk("side_light", 8'(side_light), 8'(el[2:0]));
    chk("cnt_load",   8'(cnt_load),   8'(mload));
    chk("cnt_tens",   8'(cnt_tens),   8'(mtens));
  endtask

  // Advance the model by one clock using green = T*10-3, extension = 7, yellow = 5 cycles.
  task automatic model_edge(input logic sreq, input logic inj);
    int unsigned nph, ncnt, nwin;
    logic        nlatch, nload;
    logic [1:0]  ntens;
    nph    = mph;
    ncnt   = mcnt + 1;
    nwin   = mwin;
    nlatch = mlatch | (sreq && (mph != 4));
    nload  = 1'b0;
    ntens  = mtens;
    case (mph)
      0, 3: begin
        if (mcnt == AR - 1) begin
          nph   = (mph == 0) ? 1 : 4;
          nload = 1'b1;
          ntens = (mph == 0) ? 2'(MAIN_T) : 2'(SIDE_T);
          nwin  = ((mph == 0) ? MAIN_T : SIDE_T) * 10 - 3;
          ncnt  = 0;
          if (mph == 3) nlatch = 1'b0;
        end
      end
      1: begin
        if ((mcnt == mwin - 1) || (inj && (mcnt >= 2))) begin
          ncnt = 0;
          if (mlatch) begin
            nph = 2;
          end else begin
            nload = 1'b1;
            ntens = 2'd1;
            nwin  = 7;
          end
        end
      end
      4: begin
        if (mcnt == mwin - 1) begin
          nph  = 5;
          ncnt = 0;
        end
      end
      default: begin
        if (mcnt == 4) begin
          nph  = (mph == 2) ? 3 : 0;
          ncnt = 0;
        end
      end
    endcase
    mph = nph; mcnt = ncnt; mwin = nwin; mlatch = nlatch; mload = nload; mtens = ntens;
  endtask

  // Called at a negedge: drive inputs, clock once, update the timer, check at next negedge.
  task automatic step(input logic sreq, input logic inj);
    logic       ld;
    logic [1:0] tn;
    side_req = sreq;
    inj_zero = inj;
    ld = cnt_load;
    tn = cnt_tens;
    model_edge(sreq, inj);
    @(posedge myClock);
    #1;
    inj_zero = 1'b0;
    if (ld) tmr = 10 * int'(tn);
    else if (tmr != 0) tmr = tmr - 1;
    @(negedge myClock);
    check_outputs();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    side_req = 1'b0;
    inj_zero = 1'b0;
    mph = 0; mcnt = 0; mwin = 0; mlatch = 1'b0; mload = 1'b0; mtens = 2'd0;
    #1;
    check_outputs();
    repeat (2) begin
      @(posedge myClock);
      #1;
      if (tmr != 0) tmr = tmr - 1;
      @(negedge myClock);
      check_outputs();
    end
    reset = 1'b0;
  endtask

  task automatic run_until(input int unsigned ph, input int unsigned cnt, input string tag);
    int i;
    i = 0;
    while (!((mph == ph) && (mcnt == cnt)) && (i < 400)) begin
      step(1'b0, 1'b0);
      i++;
    end
    chk(tag, 8'((mph == ph) && (mcnt == cnt)), 8'd1);
  endtask

  initial begin
    @(negedge myClock);
    do_reset();

    // Idle main road: initial load, then periodic extensions.
    repeat (2 + 27 + 7 * 5) step(1'b0, 1'b0);

    // Single side request served at the next five-check.
    step(1'b1, 1'b0);
    repeat (80) step(1'b0, 1'b0);

    // Continuous request: full cycles with no extensions.
    repeat (160) step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);

    // Reset in the middle of side yellow.
    step(1'b1, 1'b0);
    run_until(5, 2, "reach_side_y");
    do_reset();
    repeat (40) step(1'b0, 1'b0);

    // Request on the edge entering side green is dropped; next main green extends.
    step(1'b1, 1'b0);
    run_until(3, AR - 1, "reach_red_s_end");
    step(1'b1, 1'b0);
    run_until(1, 0, "reach_main_g");
    repeat (45) step(1'b0, 1'b0);

    // Premature zero: ignored in load window, treated as five afterwards.
    do_reset();
    run_until(1, 0, "reach_main_g_inj");
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    run_until(1, 10, "reach_inj_point");
    step(1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0);

    // Randomized traffic with occasional premature zeros.
    for (int i = 0; i < 1500; i++) begin
      logic s, j;
      s = ($urandom_range(0, 19) == 0);
      j = (mph == 1) && !mlatch && !s && ($urandom_range(0, 24) == 0);
      step(s, j);
    end
    repeat ($urandom_range(1, 60)) step(($urandom_range(0, 9) == 0), 1'b0);
    do_reset();
    repeat (60) step(($urandom_range(0, 9) == 0), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
